// File: rtl/ex_wb_stage.sv
// Execute stage and EX/WB pipeline register of the 8-bit pipelined datapath.
// Resolves operands with EX/WB->EX forwarding and runs the 2-bit-coded ALU.
// Registers result, destination and write-enable for register-file writeback.
// Also keeps zero/carry condition flags and a count of retired writes.
module ex_wb_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_id_ex,
    input  logic [1:0]        alu_con_id_ex,
    input  logic              alu_src_id_ex,
    input  logic [DATA_W-1:0] data1_id_ex,
    input  logic [DATA_W-1:0] data2_id_ex,
    input  logic [DATA_W-1:0] imm_id_ex,
    input  logic [REG_AW-1:0] write_reg_id_ex,
    input  logic [REG_AW-1:0] rs1_id_ex,
    input  logic [REG_AW-1:0] rs2_id_ex,
    output logic              reg_write_ex_wb,
    output logic [REG_AW-1:0] write_reg_ex_wb,
    output logic [DATA_W-1:0] result_ex_wb,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [CNT_W-1:0]  retired_cnt
);

    // ALU operation encoding as carried in alu_con_id_ex.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    alu_op_e           alu_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum_wide;
    logic [DATA_W:0]   diff_wide;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              carry_update;

    assign alu_op = alu_op_e'(alu_con_id_ex);

    // Forwarding detection: only the immediately preceding, non-bubble
    // instruction can supply an operand; r0 is an ordinary register here.
    always_comb begin
        fwd_a = reg_write_ex_wb && (write_reg_ex_wb == rs1_id_ex);
        fwd_b = reg_write_ex_wb && (write_reg_ex_wb == rs2_id_ex) && !alu_src_id_ex;
    end

    // Operand selection: immediate takes priority over forwarding on B.
    always_comb begin
        op_a = fwd_a ? result_ex_wb : data1_id_ex;
        if (alu_src_id_ex) begin
            op_b = imm_id_ex;
        end else begin
            op_b = fwd_b ? result_ex_wb : data2_id_ex;
        end
    end

    // Widened add/subtract so the top bit is the carry or borrow.
    always_comb begin
        sum_wide  = {1'b0, op_a} + {1'b0, op_b};
        diff_wide = {1'b0, op_a} - {1'b0, op_b};
    end

    // ALU result and carry; AND/OR leave the carry flag untouched.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        alu_result   = '0;
        alu_carry    = 1'b0;
        carry_update = 1'b0;
        unique case (alu_op)
            ALU_ADD: begin
                alu_result   = sum_wide[DATA_W-1:0];
                alu_carry    = sum_wide[DATA_W];
                carry_update = 1'b1;
            end
            ALU_SUB: begin
                // The wrapped-out top bit is 1 exactly when A < B unsigned.
                alu_result   = diff_wide[DATA_W-1:0];
                alu_carry    = diff_wide[DATA_W];
                carry_update = 1'b1;
            end
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            default: alu_result = '0;
        endcase
    end

    // EX/WB pipeline register: loads every cycle, bubbles included, so a
    // bubble's write-enable of 0 is what suppresses writeback and forwarding.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            reg_write_ex_wb <= 1'b0;
            write_reg_ex_wb <= '0;
            result_ex_wb    <= '0;
        end else begin
            reg_write_ex_wb <= reg_write_id_ex;
            write_reg_ex_wb <= write_reg_id_ex;
            result_ex_wb    <= alu_result;
        end
    end

    // Condition flags and retired-write counter advance only on real writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_flag   <= 1'b0;
            carry_flag  <= 1'b0;
            retired_cnt <= '0;
        end else if (reg_write_id_ex) begin
            zero_flag   <= (alu_result == '0);
            retired_cnt <= retired_cnt + 1'b1;
            if (carry_update) begin
                carry_flag <= alu_carry;
            end
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed, table-driven bench for ex_wb_stage: reset behaviour, ALU ops with
// carry/borrow, forwarding on A and B, bubble suppression, counter wrap.
module tb_ex_wb_stage;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              reg_write_id_ex;
    logic [1:0]        alu_con_id_ex;
    logic              alu_src_id_ex;
    logic [DATA_W-1:0] data1_id_ex;
    logic [DATA_W-1:0] data2_id_ex;
    logic [DATA_W-1:0] imm_id_ex;
    logic [REG_AW-1:0] write_reg_id_ex;
    logic [REG_AW-1:0] rs1_id_ex;
    logic [REG_AW-1:0] rs2_id_ex;
    logic              reg_write_ex_wb;
    logic [REG_AW-1:0] write_reg_ex_wb;
    logic [DATA_W-1:0] result_ex_wb;
    logic              zero_flag;
    logic              carry_flag;
    logic              fwd_a;
    logic              fwd_b;
    logic [CNT_W-1:0]  retired_cnt;

    int n_vec = 0;
    int n_bad = 0;

    ex_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_write_id_ex (reg_write_id_ex),
        .alu_con_id_ex   (alu_con_id_ex),
        .alu_src_id_ex   (alu_src_id_ex),
        .data1_id_ex     (data1_id_ex),
        .data2_id_ex     (data2_id_ex),
        .imm_id_ex       (imm_id_ex),
        .write_reg_id_ex (write_reg_id_ex),
        .rs1_id_ex       (rs1_id_ex),
        .rs2_id_ex       (rs2_id_ex),
        .reg_write_ex_wb (reg_write_ex_wb),
        .write_reg_ex_wb (write_reg_ex_wb),
        .result_ex_wb    (result_ex_wb),
        .zero_flag       (zero_flag),
        .carry_flag      (carry_flag),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .retired_cnt     (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic              rw;
        logic [1:0]        alu;
        logic              src;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] wr;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              e_fa;
        logic              e_fb;
        logic [DATA_W-1:0] e_res;
        logic              e_z;
        logic              e_c;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [1:0] alu, input logic src,
                         input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                         input logic [DATA_W-1:0] imm, input logic [REG_AW-1:0] wr,
                         input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
        reg_write_id_ex = rw;
        alu_con_id_ex   = alu;
        alu_src_id_ex   = src;
        data1_id_ex     = d1;
        data2_id_ex     = d2;
        imm_id_ex       = imm;
        write_reg_id_ex = wr;
        rs1_id_ex       = rs1;
        rs2_id_ex       = rs2;
    endtask

    initial begin
        //          rw alu    src d1     d2     imm    wr rs1 rs2 fa fb res    z  c  cnt
        vecs[0]  = '{1, 2'b00, 0, 8'h05, 8'h03, 8'h00, 2, 1, 1, 0, 0, 8'h08, 0, 0, 16'd1};
        vecs[1]  = '{1, 2'b00, 0, 8'hFF, 8'h01, 8'h00, 1, 3, 4, 0, 0, 8'h00, 1, 1, 16'd2};
        vecs[2]  = '{1, 2'b01, 0, 8'h03, 8'h05, 8'h00, 1, 3, 4, 0, 0, 8'hFE, 0, 1, 16'd3};
        vecs[3]  = '{1, 2'b10, 0, 8'hF0, 8'h0F, 8'h00, 6, 2, 3, 0, 0, 8'h00, 1, 1, 16'd4};
        vecs[4]  = '{1, 2'b00, 0, 8'h08, 8'h08, 8'h00, 3, 0, 7, 0, 0, 8'h10, 0, 0, 16'd5};
        vecs[5]  = '{1, 2'b01, 0, 8'h00, 8'h01, 8'h00, 4, 3, 4, 1, 0, 8'h0F, 0, 0, 16'd6};
        vecs[6]  = '{1, 2'b00, 0, 8'h08, 8'h08, 8'h00, 3, 0, 7, 0, 0, 8'h10, 0, 0, 16'd7};
        vecs[7]  = '{1, 2'b01, 1, 8'h00, 8'h55, 8'h02, 5, 3, 3, 1, 0, 8'h0E, 0, 0, 16'd8};
        vecs[8]  = '{1, 2'b00, 0, 8'hFF, 8'h01, 8'h00, 2, 0, 0, 0, 0, 8'h00, 1, 1, 16'd9};
        vecs[9]  = '{0, 2'b00, 0, 8'h40, 8'h40, 8'h00, 3, 1, 1, 0, 0, 8'h80, 1, 1, 16'd9};
        vecs[10] = '{1, 2'b11, 0, 8'h22, 8'h00, 8'h00, 4, 3, 3, 0, 0, 8'h22, 0, 1, 16'd10};
        vecs[11] = '{1, 2'b11, 0, 8'h0A, 8'h00, 8'h00, 5, 0, 0, 0, 0, 8'h0A, 0, 1, 16'd11};
        vecs[12] = '{1, 2'b00, 0, 8'h00, 8'h00, 8'h00, 6, 5, 5, 1, 1, 8'h14, 0, 0, 16'd12};
        vecs[13] = '{1, 2'b00, 0, 8'h7F, 8'h01, 8'h00, 0, 1, 2, 0, 0, 8'h80, 0, 0, 16'd13};
        vecs[14] = '{1, 2'b01, 0, 8'h33, 8'h33, 8'h00, 7, 0, 0, 1, 1, 8'h00, 1, 0, 16'd14};

        // Power-on reset, then one instruction to put non-zero state in flight.
        reset = 1'b0;
        drive(0, 2'b00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 2'b00, 0, 8'h11, 8'h22, 8'h00, 7, 7, 7);
        @(posedge clk);
        #1;
        check("pre-reset result", result_ex_wb, 8'h33);
        check("pre-reset cnt", retired_cnt, 16'd1);

        // Mid-cycle asynchronous reset with inputs still active.
        #2;
        reset = 1'b0;
        #1;
        check("async rst result", result_ex_wb, 8'h00);
        check("async rst reg_write", reg_write_ex_wb, 1'b0);
        check("async rst write_reg", write_reg_ex_wb, 3'd0);
        check("async rst zero", zero_flag, 1'b0);
        check("async rst carry", carry_flag, 1'b0);
        check("async rst cnt", retired_cnt, 16'd0);
        check("async rst fwd_a", fwd_a, 1'b0);
        @(posedge clk);
        #1;
        check("rst held across edge", result_ex_wb, 8'h00);

        // Release at a negedge; the next edge registers vector 0 normally.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            reset = 1'b1;
            drive(vecs[i].rw, vecs[i].alu, vecs[i].src, vecs[i].d1, vecs[i].d2,
                  vecs[i].imm, vecs[i].wr, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("v%0d fwd_a", i), fwd_a, vecs[i].e_fa);
            check($sformatf("v%0d fwd_b", i), fwd_b, vecs[i].e_fb);
            @(posedge clk);
            #1;
            check($sformatf("v%0d result", i), result_ex_wb, vecs[i].e_res);
            check($sformatf("v%0d reg_write", i), reg_write_ex_wb, vecs[i].rw);
            check($sformatf("v%0d write_reg", i), write_reg_ex_wb, vecs[i].wr);
            check($sformatf("v%0d zero", i), zero_flag, vecs[i].e_z);
            check($sformatf("v%0d carry", i), carry_flag, vecs[i].e_c);
            check($sformatf("v%0d cnt", i), retired_cnt, vecs[i].e_cnt);
        end

        // Counter wrap: 14 retired so far, 65521 more reaches 0xFFFF.
        @(negedge clk);
        drive(1, 2'b00, 0, 8'h00, 8'h00, 8'h00, 1, 2, 2);
        repeat (65521) @(posedge clk);
        #1;
        check("cnt at max", retired_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        check("cnt wrap to 0", retired_cnt, 16'h0000);
        @(negedge clk);
        drive(0, 2'b00, 0, 8'h01, 8'h00, 8'h00, 1, 2, 2);
        @(posedge clk);
        #1;
        check("bubble holds cnt", retired_cnt, 16'h0000);
        check("bubble reg_write", reg_write_ex_wb, 1'b0);
        check("bubble holds zero", zero_flag, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
